// File: rtl/rv32i_types.sv
// Shared rv32i type definitions: load/store funct3 encodings and the memory commit FSM states.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } mem_fsm_t;

  // funct3[1:0] encodes access size for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   is_misaligned = addr_lo[0];
      2'b10:   is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane alignment: store data replication, byte enables and load extraction.
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  st_mbe,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wdata  = st_data;
    st_mbe = 4'b1111;
    case (funct3)
      sb: begin
        wdata  = {4{st_data[7:0]}};
        st_mbe = 4'b0001 << addr_lo;
      end
      sh: begin
        wdata  = {2{st_data[15:0]}};
        st_mbe = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata  = st_data;
        st_mbe = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = rdata[7:0];
    case (addr_lo)
      2'b00: ld_byte = rdata[7:0];
      2'b01: ld_byte = rdata[15:8];
      2'b10: ld_byte = rdata[23:16];
      2'b11: ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    ld_data = rdata;
    case (funct3)
      lb:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      lh:      ld_data = {{16{ld_half[15]}}, ld_half};
      lw:      ld_data = rdata;
      lbu:     ld_data = {24'h0, ld_byte};
      lhu:     ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_commit_unit.sv
// Commits the ROB head load/store to the d-cache as a single IDLE->ACCESS->DONE transaction.
// Optional MEM_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT_CYCLES and reports timeout_err.
module mem_commit_unit
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        data_mem_resp,
  output logic [31:0] ld_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        busy,
  output logic        misalign_err,
  output logic        timeout_err
);

  mem_fsm_t    state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] st_data_q, st_data_d;
  logic        is_read_q, is_read_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        misalign_q, misalign_d;

  logic [31:0] align_wdata;
  logic [3:0]  align_mbe;
  logic [31:0] align_ld;

  mem_align u_mem_align (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .st_data (st_data_q),
    .rdata   (dmem_rdata),
    .wdata   (align_wdata),
    .st_mbe  (align_mbe),
    .ld_data (align_ld)
  );

`ifdef MEM_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    st_data_d  = st_data_q;
    is_read_d  = is_read_q;
    ld_data_d  = ld_data_q;
    misalign_d = misalign_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_read || data_write) begin
          addr_d     = addr;
          funct3_d   = funct3;
          st_data_d  = st_data;
          is_read_d  = data_read;
          ld_data_d  = '0;
          misalign_d = is_misaligned(funct3, addr[1:0]);
          // Misaligned ops skip the cache entirely and report straight from DONE.
          state_d    = misalign_d ? DONE : ACCESS;
`ifdef MEM_TIMEOUT_EN
          cnt_d      = '0;
          timeout_d  = 1'b0;
`endif
        end
      end
      ACCESS: begin
        if (dmem_resp) begin
          ld_data_d = is_read_q ? align_ld : '0;
          state_d   = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q + 32'd1 >= TIMEOUT_CYCLES) begin
          ld_data_d = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      // The ROB head advances on the DONE edge, so the still-high request is stale.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      st_data_q  <= '0;
      is_read_q  <= 1'b0;
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      st_data_q  <= st_data_d;
      is_read_q  <= is_read_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  logic in_access;
  logic in_done;

  always_comb begin
    in_access     = (state_q == ACCESS);
    in_done       = (state_q == DONE);
    busy          = (state_q != IDLE);
    dmem_read     = in_access && is_read_q;
    dmem_write    = in_access && !is_read_q;
    dmem_address  = in_access ? {addr_q[31:2], 2'b00} : '0;
    dmem_wdata    = (in_access && !is_read_q) ? align_wdata : '0;
    dmem_mbe      = in_access ? (is_read_q ? 4'b1111 : align_mbe) : 4'b0000;
    data_mem_resp = in_done;
    ld_data       = in_done ? ld_data_q : '0;
    misalign_err  = in_done && misalign_q;
`ifdef MEM_TIMEOUT_EN
    timeout_err   = in_done && timeout_q;
`else
    timeout_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_commit_unit.sv
// Directed self-checking bench for mem_commit_unit (timeout checks only when MEM_TIMEOUT_EN is set).
module tb_mem_commit_unit;

  logic        clk;
  logic        rst;
  logic        data_read;
  logic        data_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic        data_mem_resp;
  logic [31:0] ld_data;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        busy;
  logic        misalign_err;
  logic        timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mem_commit_unit #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_read     (data_read),
    .data_write    (data_write),
    .funct3        (funct3),
    .addr          (addr),
    .st_data       (st_data),
    .data_mem_resp (data_mem_resp),
    .ld_data       (ld_data),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_address  (dmem_address),
    .dmem_wdata    (dmem_wdata),
    .dmem_mbe      (dmem_mbe),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .busy          (busy),
    .misalign_err  (misalign_err),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    data_read  = 1'b0;
    data_write = 1'b0;
    funct3     = 3'b000;
    addr       = '0;
    st_data    = '0;
    dmem_rdata = '0;
    dmem_resp  = 1'b0;
  endtask

  // Full aligned transaction: request held through DONE, response after 3 strobe cycles.
  task automatic run_op(input string tag, input logic rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rword,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_mbe, input logic [31:0] exp_ld);
    data_read  = rd;
    data_write = !rd;
    funct3     = f3;
    addr       = a;
    st_data    = sd;
    tick();
    check({tag, ".strobe"}, {30'd0, dmem_read, dmem_write}, {30'd0, rd, !rd});
    check({tag, ".addr"}, dmem_address, exp_addr);
    check({tag, ".mbe"}, {28'd0, dmem_mbe}, {28'd0, exp_mbe});
    if (!rd) check({tag, ".wdata"}, dmem_wdata, exp_wdata);
    tick();
    tick();
    check({tag, ".held"}, {30'd0, dmem_read, dmem_write}, {30'd0, rd, !rd});
    dmem_rdata = rword;
    dmem_resp  = 1'b1;
    #1;
    check({tag, ".no_early_resp"}, {31'd0, data_mem_resp}, 32'd0);
    tick();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'hDEAD_BEEF;
    check({tag, ".resp"}, {31'd0, data_mem_resp}, 32'd1);
    check({tag, ".strobe_off"}, {30'd0, dmem_read, dmem_write}, 32'd0);
    if (rd) check({tag, ".ld_data"}, ld_data, exp_ld);
    tick();
    check({tag, ".resp_one_cycle"}, {31'd0, data_mem_resp}, 32'd0);
    check({tag, ".not_reaccepted"}, {31'd0, busy}, 32'd0);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.resp", {31'd0, data_mem_resp}, 32'd0);
    check("reset.strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    check("reset.mbe", {28'd0, dmem_mbe}, 32'd0);
    rst = 1'b1;
    tick();

    run_op("lw",  1'b1, 3'b010, 32'h100, '0, 32'h8899AABB, 32'h100, '0, 4'b1111, 32'h8899AABB);
    run_op("lb",  1'b1, 3'b000, 32'h103, '0, 32'h80FFFFFF, 32'h100, '0, 4'b1111, 32'hFFFFFF80);
    run_op("lbu", 1'b1, 3'b100, 32'h103, '0, 32'h80FFFFFF, 32'h100, '0, 4'b1111, 32'h00000080);
    run_op("lh",  1'b1, 3'b001, 32'h102, '0, 32'h80011234, 32'h100, '0, 4'b1111, 32'hFFFF8001);
    run_op("lhu", 1'b1, 3'b101, 32'h100, '0, 32'h8001F234, 32'h100, '0, 4'b1111, 32'h0000F234);
    run_op("sh",  1'b0, 3'b001, 32'h202, 32'h1234ABCD, '0, 32'h200, 32'hABCDABCD, 4'b1100, '0);
    run_op("sb",  1'b0, 3'b000, 32'h101, 32'h0000005A, '0, 32'h100, 32'h5A5A5A5A, 4'b0010, '0);
    run_op("sw",  1'b0, 3'b010, 32'h300, 32'hCAFEF00D, '0, 32'h300, 32'hCAFEF00D, 4'b1111, '0);

    // Misaligned LW: no strobe, DONE right after acceptance.
    data_read = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h101;
    tick();
    check("mis_lw.strobe", {30'd0, dmem_read, dmem_write}, 32'd0);
    check("mis_lw.resp", {31'd0, data_mem_resp}, 32'd1);
    check("mis_lw.err", {31'd0, misalign_err}, 32'd1);
    check("mis_lw.ld_data", ld_data, 32'd0);
    idle_inputs();
    tick();
    check("mis_lw.clear", {30'd0, misalign_err, busy}, 32'd0);

    // Misaligned SH.
    data_write = 1'b1;
    funct3     = 3'b001;
    addr       = 32'h201;
    st_data    = 32'h1111_2222;
    tick();
    check("mis_sh.strobe", {30'd0, dmem_read, dmem_write}, 32'd0);
    check("mis_sh.resp_err", {30'd0, data_mem_resp, misalign_err}, 32'd3);
    idle_inputs();
    tick();

    // Both requests high: read wins.
    data_read  = 1'b1;
    data_write = 1'b1;
    funct3     = 3'b010;
    addr       = 32'h104;
    tick();
    check("prio.strobe", {30'd0, dmem_read, dmem_write}, 32'd2);
    // Request drops mid-ACCESS; access continues.
    data_read  = 1'b0;
    data_write = 1'b0;
    tick();
    check("drop.held", {31'd0, dmem_read}, 32'd1);
    dmem_rdata = 32'h0BAD_CAFE;
    dmem_resp  = 1'b1;
    tick();
    dmem_resp  = 1'b0;
    check("drop.resp", {31'd0, data_mem_resp}, 32'd1);
    check("drop.ld_data", ld_data, 32'h0BAD_CAFE);
    tick();

    // Stray dmem_resp in IDLE is ignored.
    dmem_resp = 1'b1;
    tick();
    check("stray.resp", {31'd0, data_mem_resp}, 32'd0);
    check("stray.busy", {31'd0, busy}, 32'd0);
    dmem_resp = 1'b0;

    // Reset during ACCESS.
    data_read = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h100;
    tick();
    check("rst_mid.pre", {31'd0, dmem_read}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid.read_off", {31'd0, dmem_read}, 32'd0);
    check("rst_mid.busy", {31'd0, busy}, 32'd0);
    data_read = 1'b0;
    tick();
    rst       = 1'b1;
    dmem_resp = 1'b1;
    tick();
    check("rst_mid.no_resp", {31'd0, data_mem_resp}, 32'd0);
    dmem_resp = 1'b0;
    tick();
    check("rst_mid.no_resp2", {31'd0, data_mem_resp}, 32'd0);

    // Reset release: first request accepted at the next edge.
    rst = 1'b0;
    tick();
    rst       = 1'b1;
    data_read = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h100;
    tick();
    check("post_rst.accept", {31'd0, dmem_read}, 32'd1);

`ifdef MEM_TIMEOUT_EN
    // No response: three more ACCESS cycles, then DONE with timeout_err.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to.waiting", {31'd0, dmem_read}, 32'd1);
    end
    tick();
    check("to.resp", {31'd0, data_mem_resp}, 32'd1);
    check("to.err", {31'd0, timeout_err}, 32'd1);
    check("to.ld_data", ld_data, 32'd0);
    check("to.strobe_off", {31'd0, dmem_read}, 32'd0);
    tick();
    check("to.not_reaccepted", {30'd0, busy, dmem_read}, 32'd0);
    tick();
    check("to.reaccepted", {31'd0, dmem_read}, 32'd1);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    data_read = 1'b0;
    check("to.normal_resp", {30'd0, data_mem_resp, timeout_err}, 32'd2);
    tick();
`else
    // Without the timeout feature ACCESS waits indefinitely.
    for (int i = 0; i < 20; i++) tick();
    check("nto.waiting", {31'd0, dmem_read}, 32'd1);
    check("nto.err", {31'd0, timeout_err}, 32'd0);
    dmem_rdata = 32'h1357_9BDF;
    dmem_resp  = 1'b1;
    tick();
    dmem_resp  = 1'b0;
    data_read  = 1'b0;
    check("nto.resp", {30'd0, data_mem_resp, timeout_err}, 32'd2);
    check("nto.ld_data", ld_data, 32'h1357_9BDF);
    tick();
`endif
    check("end.idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
